// File: rtl/piso_pkg.sv
// Shared FSM state encoding for the parallel-in serial-out shifter.
// PARITY exists only when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
`ifdef PISO_PARITY_EN
        PARITY = ST_PARITY,
`endif
        SHIFT  = ST_SHIFT
    } state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the shifter: cleared at word load, advanced per
// accepted data bit, flags the final position and wraps back to zero after it.
module piso_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last_val,
    output logic [CNT_W-1:0] count,
    output logic             is_last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign is_last = (count_q == last_val);
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = is_last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter with valid/ready on both sides and a done pulse.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             done_q;
    logic             accept;
    logic             bit_xfer;
    logic             is_last;
    logic [CNT_W-1:0] bit_cnt_unused;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    assign accept   = din_valid && din_ready;
    assign bit_xfer = (state_q == SHIFT) && dout_ready;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (bit_xfer),
        .last_val (LAST_BIT),
        .count    (bit_cnt_unused),
        .is_last  (is_last)
    );

    // Shift toward the output end, zero-filling the vacated position.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end else begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        dout = 1'b0;
        case (state_q)
            SHIFT:   dout = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
`ifdef PISO_PARITY_EN
            PARITY:  dout = par_q;
`endif
            default: dout = 1'b0;
        endcase
    end

    assign dout_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign din_ready  = rst && (state_q == IDLE);
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        sr_q    <= din;
                        state_q <= SHIFT;
`ifdef PISO_PARITY_EN
                        par_q   <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    if (dout_ready) begin
                        sr_q <= sr_d;
                        if (is_last) begin
`ifdef PISO_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= IDLE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (dout_ready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        par_q   <= 1'b0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 serialises din[WIDTH-1] first; 0 serialises din[0] first.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-low.
REQ-005 Port din  input  WIDTH  parallel word to serialise.
REQ-006 Port din_valid  input  1  din holds a word for transfer.
REQ-007 Port din_ready  output  1  block can accept a word this cycle.
REQ-008 Port dout  output  1  current serial bit.
REQ-009 Port dout_valid  output  1  dout holds a valid bit.
REQ-010 Port dout_ready  input  1  sink accepts dout this cycle.
REQ-011 Port busy  output  1  a word is being serialised.
REQ-012 Port done  output  1  one-cycle pulse after the final bit of a word is accepted.

Function
REQ-013 FSM states: IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined; encoding defined in the shared package.
REQ-014 IDLE: din_ready=1, dout_valid=0, busy=0, dout=0.
REQ-015 The block accepts a word when din_valid and din_ready are both 1 at a rising edge; it loads din into the shift register, clears the bit counter, and enters SHIFT.
REQ-016 Latency: the first bit appears on dout with dout_valid=1 in the cycle after the word is accepted.
REQ-017 SHIFT: dout_valid=1, busy=1, din_ready=0; dout is the shift register MSB when MSB_FIRST=1 and the LSB when MSB_FIRST=0.
REQ-018 Each bit transfer (dout_valid and dout_ready both 1 at a rising edge) shifts the register one position toward the output end, fills the vacated position with 0, and increments the counter.
REQ-019 Stall: while dout_ready=0, the block holds dout, dout_valid, the shift register and the counter unchanged for any number of cycles.
REQ-020 The transfer with counter = WIDTH-1 is the last data bit; the block goes to IDLE, or to PARITY when PISO_PARITY_EN is defined.
REQ-021 done=1 for exactly one cycle: the cycle after the final bit transfer of a word (data or parity); otherwise done=0.
REQ-022 Minimum word period is WIDTH+1 cycles (WIDTH+2 with parity); back-to-back words are separated by one IDLE cycle.
REQ-023 din_valid while busy=1 is ignored; the word in flight is never corrupted.
REQ-024 The bit counter is sized $clog2(WIDTH) bits and never exceeds WIDTH-1.

Reset
REQ-025 While rst=0 at a rising edge: state goes to IDLE, shift register and counter clear to 0, and outputs take these values: dout=0, dout_valid=0, busy=0, done=0.
REQ-026 din_ready is forced to 0 while rst=0 and returns to 1 in the first cycle with rst=1.
REQ-027 Reset mid-word discards the word in flight; no done pulse is generated for it.

Configuration
REQ-028 Macro PISO_PARITY_EN: when defined, PARITY state presents even parity of the loaded word on dout with dout_valid=1, under the same stall rules as data bits.
REQ-029 When PISO_PARITY_EN is defined, the block latches parity at load and returns to IDLE after the parity bit is transferred.
REQ-030 When PISO_PARITY_EN is undefined, no PARITY state or parity logic exists, and the block returns to IDLE directly after the last data bit.

Structure
REQ-031 Package piso_pkg holds the FSM state typedef and the localparam constants for the state encodings.
REQ-032 The bit counter is a sub-module piso_bit_counter with inputs clr, en and last-value, and outputs count and is_last.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, din=8'hB4, dout_ready=1 -> dout 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting 1 cycle after accept; done pulses once.
REQ-034 MSB_FIRST=0, din=8'hB4 -> dout 0,0,1,0,1,1,0,1.
REQ-035 din=8'hB4, MSB first, dout_ready=0 for 3 cycles while the third bit (1) is shown -> dout=1 and dout_valid=1 are held through the stall; the remaining bits follow unchanged.
REQ-036 PISO_PARITY_EN defined, din=8'h07 -> 8 data bits then parity bit 1; done asserts after the parity transfer.
REQ-037 rst=0 asserted after 4 bits transferred -> next cycle dout_valid=0, busy=0, no done pulse; a new word after release serialises correctly.
REQ-038 din_valid held at 1 with a second word while busy -> the second word is accepted only in the IDLE cycle after done, and the first word's bits are unaffected.
